// File: rtl/serial_pkg.sv
// Types and line levels shared by the serial frame receiver and the transmit side.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } rx_state_t;

  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;

endpackage

// File: rtl/rx_hold_reg.sv
// One-deep valid/ready holding register for completed receive words.
// A new word is accepted when the register is empty or draining this cycle.
// Otherwise the new word is dropped and a one-cycle overrun pulse is raised.
module rx_hold_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic         q_valid,
  input  logic         q_ready,
  output logic         overrun
);

  logic [W-1:0] q_q, q_d;
  logic         vld_q, vld_d;
  logic         ovr_q, ovr_d;

  // Load / drain / overrun decision; q keeps its last value after a drain
  always_comb begin
    q_d   = q_q;
    vld_d = vld_q;
    ovr_d = 1'b0;
    if (load) begin
      if (!vld_q || q_ready) begin
        q_d   = din;
        vld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (vld_q && q_ready) begin
      vld_d = 1'b0;
    end
  end

  // Holding register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      vld_q <= vld_d;
      ovr_q <= ovr_d;
    end
  end

  assign q       = q_q;
  assign q_valid = vld_q;
  assign overrun = ovr_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, N data bits, stop bit,
// sampled on the en strobe; completed words go out through rx_hold_reg.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int N         = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         si,
  output logic [N-1:0] q,
  output logic         q_valid,
  input  logic         q_ready,
  output logic         busy,
  output logic         frame_err,
  output logic         overrun
);

  localparam int               CNT_W    = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic             frame_err_q, frame_err_d;
  logic             load;

  // State register and datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state: everything advances only on en strobes
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en && si == START_LVL)     state_d = DATA;
      DATA:    if (en && bit_cnt_q == CNT_LAST) state_d = STOP;
      STOP:    if (en)                        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: bit counter, shift register, word completion and framing error.
  // The counter wraps to 0 on the last data bit so it never exceeds N-1.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    load        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && si == START_LVL) bit_cnt_d = '0;
      end
      DATA: begin
        if (en) begin
          if (LSB_FIRST) shreg_d = {si, shreg_q[N-1:1]};
          else           shreg_d = {shreg_q[N-2:0], si};
          bit_cnt_d = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (en) begin
          if (si == STOP_LVL) load        = 1'b1;
          else                frame_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;

  rx_hold_reg #(.W(N)) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .din     (shreg_q),
    .q       (q),
    .q_valid (q_valid),
    .q_ready (q_ready),
    .overrun (overrun)
  );

endmodule
